// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving a register-file datapath control word.
// Optional HALT opcode (OP F) is enabled by defining CU_HALT_EN; otherwise OP F is a NOP.
module control_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IMEM_REQ,
    output logic [15:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [15:0] IMEM_RDATA,
    output logic [15:0] CTRWRD,
    output logic [15:0] Cin,
    input  logic        V,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    output logic        HALTED
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_EXEC2,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [3:0]  flags_q, flags_d;

    logic [3:0]  op;
    logic [2:0]  dr, sa, sb;
    logic [5:0]  imm6;
    logic        taken;

    logic [2:0]  da, aa, ba;
    logic        mb, md, rw;
    logic [3:0]  fs;
    logic [15:0] cin_w;

    assign op   = ir_q[15:12];
    assign dr   = ir_q[11:9];
    assign sa   = ir_q[8:6];
    assign sb   = ir_q[5:3];
    assign imm6 = ir_q[5:0];

    // flags_q holds {V, C, N, Z} as sampled at the end of the branch EXEC cycle
    always_comb begin
        case (dr)
            3'd0:    taken = flags_q[0];
            3'd1:    taken = flags_q[1];
            3'd2:    taken = flags_q[3];
            3'd3:    taken = flags_q[2];
            3'd4:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (IMEM_ACK) begin
                    ir_d    = IMEM_RDATA;
                    pc_d    = pc_q + 16'd1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    4'hD: state_d = S_EXEC2;
                    4'hE: begin
                        flags_d = {V, C, N, Z};
                        state_d = S_EXEC2;
                    end
`ifdef CU_HALT_EN
                    4'hF: state_d = S_HALT;
`endif
                    default: state_d = S_FETCH;
                endcase
            end
            S_EXEC2: begin
                if (op == 4'hE && taken) begin
                    pc_d = pc_q + {{10{imm6[5]}}, imm6};
                end
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

    // Control word is decoded from state, so an asynchronous reset zeroes it at once
    always_comb begin
        da    = '0;
        aa    = '0;
        ba    = '0;
        mb    = 1'b0;
        fs    = '0;
        md    = 1'b0;
        rw    = 1'b0;
        cin_w = '0;
        if (state_q == S_EXEC) begin
            if (op >= 4'h1 && op <= 4'hC) begin
                da = dr;
                aa = sa;
                ba = sb;
                rw = 1'b1;
            end
            case (op)
                4'h1: fs = 4'b0000;
                4'h2: fs = 4'b0001;
                4'h3: fs = 4'b0010;
                4'h4: fs = 4'b0101;
                4'h5: fs = 4'b1000;
                4'h6: fs = 4'b1001;
                4'h7: fs = 4'b1010;
                4'h8: fs = 4'b1011;
                4'h9: fs = 4'b1101;
                4'hA: fs = 4'b1110;
                4'hB: begin
                    mb    = 1'b1;
                    fs    = 4'b1100;
                    cin_w = {10'b0, imm6};
                end
                4'hC: begin
                    mb    = 1'b1;
                    fs    = 4'b0010;
                    cin_w = {10'b0, imm6};
                end
                4'hD:    aa = sa;
                4'hE:    aa = sa;
                default: ;
            endcase
        end else if (state_q == S_EXEC2 && op == 4'hD) begin
            da = dr;
            aa = sa;
            md = 1'b1;
            rw = 1'b1;
        end
    end

    assign CTRWRD    = {da, aa, ba, mb, fs, md, rw};
    assign Cin       = cin_w;
    assign IMEM_REQ  = (state_q == S_FETCH);
    assign IMEM_ADDR = pc_q;
`ifdef CU_HALT_EN
    assign HALTED    = (state_q == S_HALT);
`else
    assign HALTED    = 1'b0;
`endif

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle instruction sequencer that sits directly upstream of the register-file/function-unit datapath. Fetches 16-bit instructions over a request/acknowledge port, decodes them into the datapath's 16-bit control word and constant input, and sequences loads and flag-conditional branches. Datapath status flags V, C, N and Z feed back from the datapath.

## Interface
- RESET_PC, 16'h0000, PC value loaded by reset.
- CLK  input  1  single clock, all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- IMEM_REQ  output  1  instruction fetch request.
- IMEM_ADDR  output  16  fetch address (current PC).
- IMEM_ACK  input  1  fetch data valid this cycle.
- IMEM_RDATA  input  16  instruction word, sampled only with IMEM_ACK in FETCH.
- CTRWRD  output  16  datapath control word: DA[15:13] AA[12:10] BA[9:7] MB[6] FS[5:2] MD[1] RW[0].
- Cin  output  16  datapath constant input.
- V, C, N, Z  input  1 each  datapath flags (combinational from current CTRWRD).
- HALTED  output  1  halt indicator.

## Operation
- Instruction fields: OP[15:12], DR[11:9], SA[8:6], SB[5:3], IMM6[5:0].
- States: IDLE, FETCH, EXEC, EXEC2, HALT. IDLE -> FETCH unconditionally.
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC, CTRWRD=0. On IMEM_ACK: IR<=IMEM_RDATA, PC<=PC+1, go to EXEC. IMEM_ACK outside FETCH is ignored.
- EXEC single-cycle ops drive DA=DR, AA=SA, BA=SB, MD=0, RW=1, then go to FETCH:
  - 1 MOVA FS0000, 2 INC 0001, 3 ADD 0010, 4 SUB 0101, 5 AND 1000, 6 OR 1001, 7 XOR 1010, 8 NOT 1011, 9 SHR 1101, A SHL 1110.
  - B LDI: MB=1, FS=1100, Cin=zero-extended IMM6.
  - C ADI: MB=1, FS=0010, Cin=zero-extended IMM6.
  - 0 NOP: CTRWRD=0 (RW=0).
- D LD:
  - EXEC is the address phase: AA=SA, RW=0, MD=0, Adrout=R[SA].
  - EXEC2: DA=DR, AA=SA, MD=1, RW=1.
  - Then go to FETCH.
- E branch:
  - EXEC: AA=SA, FS=0000, RW=0; latch V,C,N,Z at end of EXEC.
  - EXEC2: CTRWRD=0; condition code is the DR field: 000 Z, 001 N, 010 V, 011 C, 100 always, others never.
  - Taken: PC<=PC+sext(IMM6), where PC already points to the next instruction.
  - Then go to FETCH.
- F: see Configuration.
- Cin=0 whenever the instruction is not LDI/ADI.
- CTRWRD and Cin decode combinationally from state and IR.
- Reset values: state IDLE, PC=RESET_PC, IR=0, flag latch=0, CTRWRD=16'h0000, Cin=0, IMEM_REQ=0, IMEM_ADDR=RESET_PC, HALTED=0.

## Timing
- ALU/immediate/NOP instructions: 2 cycles (FETCH with same-cycle ACK, then EXEC).
- LD and branch: 3 cycles.
- Each FETCH wait cycle adds 1.
- Register write takes effect at the rising edge ending EXEC (or EXEC2 for LD).
- PC arithmetic is modulo 2^16: 16'hFFFF+1=0, and branch offsets wrap.
- Reset asserted mid-EXEC/EXEC2: CTRWRD forced to 0 immediately, so no datapath write occurs at the next edge. A pending fetch is abandoned.
- IMEM_ADDR is stable for the whole time IMEM_REQ is high.

## Configuration
- CU_HALT_EN defined:
  - OP F enters HALT after EXEC; HALT drives CTRWRD=0, IMEM_REQ=0, HALTED=1.
  - HALT is left only by reset.
- CU_HALT_EN undefined: OP F decodes as NOP, and HALTED is tied to 0.

## Test plan
- Reset release with RESET_PC=16'h0010: IMEM_REQ rises one cycle after IDLE, with IMEM_ADDR=0010 and CTRWRD=0000.
- Instruction 16'hB2_05 (LDI R1,5) with same-cycle ACK: EXEC drives CTRWRD=001_000_000_1_1100_0_1, Cin=0005. Next cycle FETCH at PC+1.
- Instruction 16'h3A50 (ADD R5,R1,R2): EXEC drives CTRWRD=101_001_010_0_0010_0_1, total 2 cycles. With ACK delayed 3 cycles: total 5 cycles, IMEM_ADDR held.
- Branch 16'hE03E (BRZ R0, offset -2) at PC 0020 with Z=1 in EXEC: next fetch at 001F. Same with Z=0: next fetch at 0021.
- LD 16'hD440 (R2<=M[R1]): EXEC has RW=0, EXEC2 CTRWRD=010_001_000_0_0000_1_1.
- Reset pulse during EXEC of an ADD: CTRWRD=0 immediately, PC returns to RESET_PC.
- With CU_HALT_EN, 16'hF000 gives HALTED=1 and no further IMEM_REQ. Without it, fetch continues at PC+1.
